// File: rtl/hazard_scoreboard.sv
// Pipeline hazard controller with a per-register countdown scoreboard for long ops; optional HAZARD_PERF_EN perf counters, DEBUG_HAZARD trace.
// Latency: hazard_signal/sb_busy combinational, scoreboard updates on the next rising edge.
// Backpressure: none accepted; stalls are issued to IF/ID via hazard_signal.
module hazard_scoreboard #(
  parameter int NREG    = 32,
  parameter int REGW    = $clog2(NREG),
  parameter int MAX_LAT = 8,
  parameter int CNTW    = $clog2(MAX_LAT + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [REGW-1:0] IFrs1,
  input  logic [REGW-1:0] IFrs2,
  input  logic [REGW-1:0] IDrd,
  input  logic            IDmemRead,
  input  logic            IDlong,
  input  logic [CNTW-1:0] IDlong_lat,
  input  logic            PCSel,
  input  logic            jump_taken,
  input  logic            stall_IMEM,
  input  logic            stall_DMEM,
  output logic [3:0]      hazard_signal,
  output logic            sb_busy,
  output logic [31:0]     perf_stall,
  output logic [31:0]     perf_flush
);

  localparam logic [3:0] HS_DN       = 4'b0000;
  localparam logic [3:0] STALL_EARLY = 4'b0001;
  localparam logic [3:0] STALL_MMU   = 4'b0010;
  localparam logic [3:0] FLUSH_EARLY = 4'b0100;
  localparam logic [3:0] FLUSH_ALL   = 4'b1000;

  logic [CNTW-1:0] cnt_q [NREG];
  logic [CNTW-1:0] cnt_d [NREG];
  logic [CNTW-1:0] lat_clamped;
  logic            issue;
  logic            haz_rs1;
  logic            haz_rs2;

  // A count of 1 means the result is forwardable this cycle, so only >1 stalls.
  always_comb begin
    haz_rs1 = (IFrs1 != '0) &&
              (((IDmemRead || IDlong) && (IDrd == IFrs1)) || (cnt_q[IFrs1] > CNTW'(1)));
    haz_rs2 = (IFrs2 != '0) &&
              (((IDmemRead || IDlong) && (IDrd == IFrs2)) || (cnt_q[IFrs2] > CNTW'(1)));
  end

  always_comb begin
    if (PCSel)                          hazard_signal = FLUSH_ALL;
    else if (jump_taken)                hazard_signal = FLUSH_EARLY;
    else if (stall_IMEM || stall_DMEM)  hazard_signal = STALL_MMU;
    else if (haz_rs1 || haz_rs2)        hazard_signal = STALL_EARLY;
    else                                hazard_signal = HS_DN;
  end

  always_comb begin
    issue = IDlong && (IDrd != '0) && !PCSel && !stall_IMEM && !stall_DMEM;
    if (IDlong_lat <= CNTW'(1))            lat_clamped = CNTW'(1);
    else if (IDlong_lat > CNTW'(MAX_LAT))  lat_clamped = CNTW'(MAX_LAT);
    else                                   lat_clamped = IDlong_lat;
  end

  // Flushes never clear counters: in-flight ops are older than the redirect.
  always_comb begin
    cnt_d[0] = '0;
    for (int r = 1; r < NREG; r++) begin
      cnt_d[r] = cnt_q[r];
      if (rst)                                cnt_d[r] = '0;
      else if (issue && (IDrd == REGW'(r)))   cnt_d[r] = lat_clamped;
      else if (cnt_q[r] != '0)                cnt_d[r] = cnt_q[r] - CNTW'(1);
    end
  end

  always_ff @(posedge clk) begin
    for (int r = 0; r < NREG; r++) cnt_q[r] <= cnt_d[r];
  end

  always_comb begin
    sb_busy = 1'b0;
    for (int r = 1; r < NREG; r++) sb_busy = sb_busy | (cnt_q[r] != '0);
  end

`ifdef HAZARD_PERF_EN
  logic [31:0] perf_stall_q, perf_stall_d;
  logic [31:0] perf_flush_q, perf_flush_d;

  always_comb begin
    perf_stall_d = perf_stall_q;
    perf_flush_d = perf_flush_q;
    if (rst) begin
      perf_stall_d = '0;
      perf_flush_d = '0;
    end else begin
      if ((hazard_signal == STALL_MMU || hazard_signal == STALL_EARLY) && perf_stall_q != 32'hFFFF_FFFF)
        perf_stall_d = perf_stall_q + 32'd1;
      if ((hazard_signal == FLUSH_ALL || hazard_signal == FLUSH_EARLY) && perf_flush_q != 32'hFFFF_FFFF)
        perf_flush_d = perf_flush_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    perf_stall_q <= perf_stall_d;
    perf_flush_q <= perf_flush_d;
  end

  assign perf_stall = perf_stall_q;
  assign perf_flush = perf_flush_q;
`else
  assign perf_stall = 32'd0;
  assign perf_flush = 32'd0;
`endif

`ifdef DEBUG_HAZARD
  always @(posedge clk) begin
    $display("[hazard] t=%0t hs=%b busy=%b", $time, hazard_signal, sb_busy);
    for (int r = 1; r < NREG; r++)
      if (cnt_q[r] != '0) $display("[hazard]   cnt[%0d]=%0d", r, cnt_q[r]);
  end
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Randomized + directed bench for hazard_scoreboard: driver pushes reference-model expectations, monitor pops and compares.
module tb_hazard_scoreboard;

  localparam logic [3:0] HS_DN       = 4'b0000;
  localparam logic [3:0] STALL_EARLY = 4'b0001;
  localparam logic [3:0] STALL_MMU   = 4'b0010;
  localparam logic [3:0] FLUSH_EARLY = 4'b0100;
  localparam logic [3:0] FLUSH_ALL   = 4'b1000;
  localparam int MAXL = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  IFrs1, IFrs2, IDrd;
  logic        IDmemRead, IDlong;
  logic [3:0]  IDlong_lat;
  logic        PCSel, jump_taken, stall_IMEM, stall_DMEM;
  logic [3:0]  hazard_signal;
  logic        sb_busy;
  logic [31:0] perf_stall, perf_flush;

  hazard_scoreboard dut (
    .clk(clk), .rst(rst), .IFrs1(IFrs1), .IFrs2(IFrs2), .IDrd(IDrd),
    .IDmemRead(IDmemRead), .IDlong(IDlong), .IDlong_lat(IDlong_lat),
    .PCSel(PCSel), .jump_taken(jump_taken), .stall_IMEM(stall_IMEM), .stall_DMEM(stall_DMEM),
    .hazard_signal(hazard_signal), .sb_busy(sb_busy),
    .perf_stall(perf_stall), .perf_flush(perf_flush)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  hs;
    logic        busy;
    logic [31:0] ps;
    logic [31:0] pf;
    string       tag;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  bit   done = 0;

  // Reference state: outstanding cycles per register and perf totals.
  int          m_cnt [32];
  longint      m_ps, m_pf;

  function automatic bit src_hazard(int rs);
    if (rs == 0) return 0;
    if ((IDmemRead || IDlong) && int'(IDrd) == rs) return 1;
    return m_cnt[rs] > 1;
  endfunction

  function automatic logic [3:0] model_hs();
    if (PCSel) return FLUSH_ALL;
    if (jump_taken) return FLUSH_EARLY;
    if (stall_IMEM || stall_DMEM) return STALL_MMU;
    if (src_hazard(int'(IFrs1)) || src_hazard(int'(IFrs2))) return STALL_EARLY;
    return HS_DN;
  endfunction

  task automatic step(input string tag,
                      input int rs1, input int rs2, input int rd,
                      input bit mr, input bit lg, input int lat,
                      input bit pc, input bit jt, input bit si, input bit sd, input bit r);
    exp_t e;
    logic [3:0] hs;
    bit busy;
    #1;
    IFrs1 = 5'(rs1); IFrs2 = 5'(rs2); IDrd = 5'(rd);
    IDmemRead = mr; IDlong = lg; IDlong_lat = 4'(lat);
    PCSel = pc; jump_taken = jt; stall_IMEM = si; stall_DMEM = sd; rst = r;
    hs = model_hs();
    busy = 0;
    foreach (m_cnt[i]) if (m_cnt[i] != 0) busy = 1;
    e.hs = hs; e.busy = busy; e.tag = tag;
`ifdef HAZARD_PERF_EN
    e.ps = 32'(m_ps); e.pf = 32'(m_pf);
`else
    e.ps = 32'd0; e.pf = 32'd0;
`endif
    exp_q.push_back(e);
    @(posedge clk);
    if (r) begin
      foreach (m_cnt[i]) m_cnt[i] = 0;
      m_ps = 0; m_pf = 0;
    end else begin
      int ld;
      bit iss;
      iss = lg && rd != 0 && !pc && !si && !sd;
      ld = (lat < 1) ? 1 : ((lat > MAXL) ? MAXL : lat);
      for (int i = 1; i < 32; i++) begin
        if (iss && i == rd) m_cnt[i] = ld;
        else if (m_cnt[i] > 0) m_cnt[i] = m_cnt[i] - 1;
      end
      if ((hs == STALL_MMU || hs == STALL_EARLY) && m_ps < 64'hFFFF_FFFF) m_ps++;
      if ((hs == FLUSH_ALL || hs == FLUSH_EARLY) && m_pf < 64'hFFFF_FFFF) m_pf++;
    end
  endtask

  task automatic idle(input string tag, input int rs1);
    step(tag, rs1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      vectors++;
      if (hazard_signal !== e.hs || sb_busy !== e.busy || perf_stall !== e.ps || perf_flush !== e.pf) begin
        miscompares++;
        $display("FAIL %s: got hs=%b busy=%b ps=%0d pf=%0d, expected hs=%b busy=%b ps=%0d pf=%0d",
                 e.tag, hazard_signal, sb_busy, perf_stall, perf_flush, e.hs, e.busy, e.ps, e.pf);
      end
    end
  end

  initial begin
    foreach (m_cnt[i]) m_cnt[i] = 0;
    m_ps = 0; m_pf = 0;
    rst = 1; IFrs1 = 0; IFrs2 = 0; IDrd = 0; IDmemRead = 0; IDlong = 0; IDlong_lat = 0;
    PCSel = 0; jump_taken = 0; stall_IMEM = 0; stall_DMEM = 0;
    @(posedge clk);
    @(posedge clk);
    step("reset_hold", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    idle("after_reset", 0);
    idle("after_reset2", 0);

    step("load_use", 0, 5, 5, 1, 0, 0, 0, 0, 0, 0, 0);
    step("load_use_rd0", 0, 5, 0, 1, 0, 0, 0, 0, 0, 0, 0);

    step("long_issue", 7, 0, 7, 0, 1, 4, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) idle("long_wait", 7);

    step("prio_setup", 0, 0, 3, 0, 1, 5, 0, 0, 0, 0, 0);
    step("prio_flush_all", 3, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0);
    step("prio_flush_early", 3, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) idle("prio_count", 3);

    step("lat_clamp", 0, 0, 10, 0, 1, 15, 0, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) idle("lat_clamp_wait", 10);

    step("waw_first", 0, 0, 11, 0, 1, 4, 0, 0, 0, 0, 0);
    idle("waw_wait", 11);
    idle("waw_wait", 11);
    step("waw_reissue", 11, 0, 11, 0, 1, 6, 0, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) idle("waw_drain", 11);

    step("issue_dmem", 0, 0, 12, 0, 1, 5, 0, 0, 0, 1, 0);
    idle("issue_dmem_noload", 12);

    step("rst_setup", 0, 0, 9, 0, 1, 6, 0, 0, 0, 0, 0);
    idle("rst_pre", 9);
    step("rst_pulse", 9, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    idle("rst_after", 9);
    step("perf_st1", 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    step("perf_st2", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    step("perf_st3", 0, 5, 5, 1, 0, 0, 0, 0, 0, 0, 0);
    step("perf_fl1", 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    step("perf_fl2", 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    idle("perf_read", 0);

    for (int n = 0; n < 600; n++) begin
      int sel;
      sel = $urandom_range(0, 99);
      step("random",
           $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
           sel < 15, $urandom_range(0, 3) == 0, $urandom_range(0, 15),
           $urandom_range(0, 19) == 0, $urandom_range(0, 14) == 0,
           $urandom_range(0, 14) == 0, $urandom_range(0, 14) == 0,
           $urandom_range(0, 149) == 0);
    end
    done = 1;
  end

  initial begin
    fork
      wait (done);
      #200000;
    join_any
    disable fork;
    if (!done) begin
      miscompares++;
      $display("FAIL timeout: stimulus incomplete, required completion");
    end
    @(negedge clk);
    @(negedge clk);
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
